// File: rtl/vram_burst_control.sv
// rtl/vram_burst_control.sv - byte-command engine running timed read/write bursts on a VRAM-style bus
module vram_burst_control #(
    parameter int ADDR_W   = 15,
    parameter int CHANNELS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            read_data_i,
    input  logic                  read_valid_i,
    output logic [7:0]            write_data_o,
    output logic                  write_valid_o,
    input  logic                  write_ready_i,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  rd_n_o,
    output logic [CHANNELS-1:0]   wr_n_o,
    output logic                  dir_o,
    output logic [8*CHANNELS-1:0] data_o,
    input  logic [8*CHANNELS-1:0] data_i,
    output logic                  busy_o,
    output logic                  error_bad_opcode_o,
    output logic                  error_overrun_o
);
    localparam int AB = (ADDR_W + 7) / 8;
    localparam int OB = (AB > CHANNELS) ? AB : CHANNELS;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_ARG, S_EXEC, S_SETUP, S_STROBE, S_HOLD, S_OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            opcode_q, opcode_d, arg_q, arg_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [8*CHANNELS-1:0] data_q, data_d;
    logic [7:0]            pulse_q, pulse_d, strobe_cnt_q, strobe_cnt_d;
    logic                  autoinc_q, autoinc_d;
    logic                  is_write_q, is_write_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;
    logic [8:0]            remaining_q, remaining_d;
    logic [8*OB-1:0]       out_buf_q, out_buf_d;
    logic [2:0]            out_cnt_q, out_cnt_d;
    logic                  wvalid_q, wvalid_d;
    logic                  err_bad_q, err_bad_d, err_ovr_q, err_ovr_d;
    logic [8*AB-1:0]       addr_ext;
    logic                  hit;

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        arg_d        = arg_q;
        addr_d       = addr_q;
        data_d       = data_q;
        pulse_d      = pulse_q;
        strobe_cnt_d = strobe_cnt_q;
        autoinc_d    = autoinc_q;
        is_write_d   = is_write_q;
        mask_d       = mask_q;
        remaining_d  = remaining_q;
        out_buf_d    = out_buf_q;
        out_cnt_d    = out_cnt_q;
        wvalid_d     = wvalid_q;
        err_bad_d    = err_bad_q;
        err_ovr_d    = err_ovr_q;
        hit          = 1'b0;
        addr_ext     = '0;
        addr_ext[ADDR_W-1:0] = addr_q;

        if (read_valid_i && state_q != S_IDLE && state_q != S_WAIT_ARG)
            err_ovr_d = 1'b1;

        case (state_q)
            S_IDLE: if (read_valid_i) begin
                opcode_d = read_data_i;
                state_d  = S_WAIT_ARG;
            end
            S_WAIT_ARG: if (read_valid_i) begin
                arg_d   = read_data_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (opcode_q)
                    8'h00: ;
                    8'h01: begin
                        out_buf_d      = '0;
                        out_buf_d[7:0] = arg_q;
                        out_cnt_d      = 3'd1;
                        wvalid_d       = 1'b1;
                        state_d        = S_OUTPUT;
                    end
                    8'h10: begin
                        addr_d    = '0;
                        data_d    = '0;
                        pulse_d   = 8'd1;
                        autoinc_d = 1'b0;
                        err_bad_d = 1'b0;
                        err_ovr_d = 1'b0;
                        wvalid_d  = 1'b0;
                    end
                    8'h40: pulse_d = (arg_q == 8'd0) ? 8'd1 : arg_q;
                    8'h41: autoinc_d = arg_q[0];
                    8'h50: begin
                        remaining_d = (arg_q == 8'd0) ? 9'd256 : {1'b0, arg_q};
                        is_write_d  = 1'b0;
                        state_d     = S_SETUP;
                    end
                    8'h60: begin
                        mask_d     = arg_q[CHANNELS-1:0];
                        is_write_d = 1'b1;
                        state_d    = S_SETUP;
                    end
                    8'hB0: begin
                        // Reverse byte order so the buffer always drains from its low byte.
                        out_buf_d = '0;
                        for (int j = 0; j < AB; j++)
                            out_buf_d[8*j +: 8] = addr_ext[8*(AB-1-j) +: 8];
                        out_cnt_d = 3'(AB);
                        wvalid_d  = 1'b1;
                        state_d   = S_OUTPUT;
                    end
                    default: begin
                        if (opcode_q[7:4] == 4'h2) begin
                            for (int i = 0; i < AB; i++)
                                if (opcode_q[3:0] == 4'(i)) begin
                                    addr_ext[8*i +: 8] = arg_q;
                                    hit = 1'b1;
                                end
                            addr_d = addr_ext[ADDR_W-1:0];
                        end else if (opcode_q[7:4] == 4'h3) begin
                            for (int i = 0; i < CHANNELS; i++)
                                if (opcode_q[3:0] == 4'(i)) begin
                                    data_d[8*i +: 8] = arg_q;
                                    hit = 1'b1;
                                end
                        end
                        if (!hit)
                            err_bad_d = 1'b1;
                    end
                endcase
            end
            S_SETUP: begin
                strobe_cnt_d = pulse_q - 8'd1;
                state_d      = S_STROBE;
            end
            S_STROBE: begin
                if (strobe_cnt_q == 8'd0) begin
                    if (!is_write_q) begin
                        out_buf_d = '0;
                        out_buf_d[8*CHANNELS-1:0] = data_i;
                    end
                    state_d = S_HOLD;
                end else begin
                    strobe_cnt_d = strobe_cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (is_write_q) begin
                    if (autoinc_q) addr_d = addr_q + ADDR_W'(1);
                    state_d = S_IDLE;
                end else begin
                    out_cnt_d = 3'(CHANNELS);
                    wvalid_d  = 1'b1;
                    state_d   = S_OUTPUT;
                end
            end
            S_OUTPUT: if (wvalid_q && write_ready_i) begin
                out_buf_d = out_buf_q >> 8;
                out_cnt_d = out_cnt_q - 3'd1;
                if (out_cnt_q == 3'd1) begin
                    wvalid_d = 1'b0;
                    state_d  = S_IDLE;
                    // A nonzero remaining count marks this output as part of a read burst.
                    if (remaining_q != 9'd0) begin
                        if (autoinc_q) addr_d = addr_q + ADDR_W'(1);
                        remaining_d = remaining_q - 9'd1;
                        if (remaining_q != 9'd1) state_d = S_SETUP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            arg_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            pulse_q      <= 8'd1;
            strobe_cnt_q <= '0;
            autoinc_q    <= 1'b0;
            is_write_q   <= 1'b0;
            mask_q       <= '0;
            remaining_q  <= '0;
            out_buf_q    <= '0;
            out_cnt_q    <= '0;
            wvalid_q     <= 1'b0;
            err_bad_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            arg_q        <= arg_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            pulse_q      <= pulse_d;
            strobe_cnt_q <= strobe_cnt_d;
            autoinc_q    <= autoinc_d;
            is_write_q   <= is_write_d;
            mask_q       <= mask_d;
            remaining_q  <= remaining_d;
            out_buf_q    <= out_buf_d;
            out_cnt_q    <= out_cnt_d;
            wvalid_q     <= wvalid_d;
            err_bad_q    <= err_bad_d;
            err_ovr_q    <= err_ovr_d;
        end
    end

    assign write_data_o       = out_buf_q[7:0];
    assign write_valid_o      = wvalid_q;
    assign addr_o             = addr_q;
    assign data_o             = data_q;
    assign rd_n_o             = !(state_q == S_STROBE && !is_write_q);
    assign wr_n_o             = (state_q == S_STROBE && is_write_q) ? ~mask_q : '1;
    assign dir_o              = is_write_q && (state_q == S_SETUP || state_q == S_STROBE ||
                                               state_q == S_HOLD);
    assign busy_o             = (state_q != S_IDLE);
    assign error_bad_opcode_o = err_bad_q;
    assign error_overrun_o    = err_ovr_q;
endmodule

// File: tb/tb_vram_burst_control.sv
// tb/tb_vram_burst_control.sv - randomized bench against a transaction-level model of vram_burst_control
module tb_vram_burst_control;
    localparam int ADDR_W = 15;
    localparam int CH     = 2;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        read_data_i = 8'h00;
    logic              read_valid_i = 1'b0;
    logic [7:0]        write_data_o;
    logic              write_valid_o;
    logic              write_ready_i = 1'b1;
    logic [ADDR_W-1:0] addr_o;
    logic              rd_n_o;
    logic [CH-1:0]     wr_n_o;
    logic              dir_o;
    logic [8*CH-1:0]   data_o;
    logic [8*CH-1:0]   data_i;
    logic              busy_o;
    logic              error_bad_opcode_o;
    logic              error_overrun_o;

    vram_burst_control #(.ADDR_W(ADDR_W), .CHANNELS(CH)) dut (
        .clock(clock), .reset(reset),
        .read_data_i(read_data_i), .read_valid_i(read_valid_i),
        .write_data_o(write_data_o), .write_valid_o(write_valid_o), .write_ready_i(write_ready_i),
        .addr_o(addr_o), .rd_n_o(rd_n_o), .wr_n_o(wr_n_o), .dir_o(dir_o),
        .data_o(data_o), .data_i(data_i), .busy_o(busy_o),
        .error_bad_opcode_o(error_bad_opcode_o), .error_overrun_o(error_overrun_o)
    );

    always #5 clock = ~clock;

    // Bus-side memory image: fixed words at the two addresses the wrap test visits.
    function automatic logic [15:0] mem_f(input int a);
        if (a == 32'h7FFF) return 16'h1122;
        if (a == 0)        return 16'h3344;
        return 16'((a * 37) ^ 32'h5AC3);
    endfunction
    assign data_i = mem_f(int'(addr_o));

    int n_cmp = 0, n_fail = 0;
    int m_addr, m_pulse, m_autoinc, m_bad, m_ovr;
    logic [15:0] m_data;
    int e_rd, e_wr0, e_wr1, e_dir;
    int rd_low, wr_low0, wr_low1, dir_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic rdy_rand = 1'b0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clock); #1;
        write_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) begin
        if (reset) begin
            if (!rd_n_o)    rd_low++;
            if (!wr_n_o[0]) wr_low0++;
            if (!wr_n_o[1]) wr_low1++;
            if (dir_o)      dir_cnt++;
            if (write_valid_o) chk("rd_n_high_in_output", 32'(rd_n_o), 1);
            if (prev_rst && prev_valid && !prev_ready) begin
                chk("valid_held", 32'(write_valid_o), 1);
                chk("data_held", 32'(write_data_o), 32'(prev_data));
            end
            if (write_valid_o && write_ready_i) begin
                got_q.push_back(write_data_o);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", write_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (write_data_o !== e) begin
                        n_fail++;
                        $display("FAIL resp_byte: got 0x%0h expected 0x%0h", write_data_o, e);
                    end
                end
            end
        end
        prev_valid = write_valid_o;
        prev_ready = write_ready_i;
        prev_data  = write_data_o;
        prev_rst   = reset;
    end

    task automatic model_reset();
        m_addr = 0; m_pulse = 1; m_autoinc = 0; m_bad = 0; m_ovr = 0; m_data = 16'h0;
    endtask

    // Applies one command to the model; returns 1 for a valid READ.
    task automatic model_cmd(input logic [7:0] op, input logic [7:0] arg, output bit is_read);
        int n;
        is_read = 0;
        e_rd = 0; e_wr0 = 0; e_wr1 = 0; e_dir = 0;
        if (op == 8'h00) begin
        end else if (op == 8'h01) begin
            exp_q.push_back(arg);
        end else if (op == 8'h10) begin
            model_reset();
        end else if (op == 8'h20 || op == 8'h21) begin
            n = 8 * int'(op[0]);
            m_addr = ((m_addr & ~(255 << n)) | (int'(arg) << n)) & AMASK;
        end else if (op == 8'h30) begin
            m_data[7:0] = arg;
        end else if (op == 8'h31) begin
            m_data[15:8] = arg;
        end else if (op == 8'h40) begin
            m_pulse = (arg == 0) ? 1 : int'(arg);
        end else if (op == 8'h41) begin
            m_autoinc = int'(arg[0]);
        end else if (op == 8'h50) begin
            is_read = 1;
            n = (arg == 0) ? 256 : int'(arg);
            e_rd = n * m_pulse;
            for (int i = 0; i < n; i++) begin
                logic [15:0] w;
                w = mem_f(m_addr);
                exp_q.push_back(w[7:0]);
                exp_q.push_back(w[15:8]);
                if (m_autoinc != 0) m_addr = (m_addr + 1) & AMASK;
            end
        end else if (op == 8'h60) begin
            e_dir = m_pulse + 2;
            e_wr0 = arg[0] ? m_pulse : 0;
            e_wr1 = arg[1] ? m_pulse : 0;
            if (m_autoinc != 0) m_addr = (m_addr + 1) & AMASK;
        end else if (op == 8'hB0) begin
            exp_q.push_back(8'((m_addr >> 8) & 255));
            exp_q.push_back(8'(m_addr & 255));
        end else begin
            m_bad = 1;
        end
    endtask

    task automatic post_check();
        chk("addr_o", 32'(addr_o), m_addr);
        chk("data_o", 32'(data_o), 32'(m_data));
        chk("err_bad", 32'(error_bad_opcode_o), m_bad);
        chk("err_ovr", 32'(error_overrun_o), m_ovr);
        chk("rd_n_idle", 32'(rd_n_o), 1);
        chk("wr_n_idle", 32'(wr_n_o), 3);
        chk("dir_idle", 32'(dir_o), 0);
        chk("bytes_left", exp_q.size(), 0);
        chk("rd_low_clks", rd_low, e_rd);
        chk("wr0_low_clks", wr_low0, e_wr0);
        chk("wr1_low_clks", wr_low1, e_wr1);
        chk("dir_high_clks", dir_cnt, e_dir);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg,
                            input int inj_dly, input int rst_dly);
        bit is_read;
        int p, lat, t, gap;
        p = m_pulse;
        model_cmd(op, arg, is_read);
        @(posedge clock); #1;
        rd_low = 0; wr_low0 = 0; wr_low1 = 0; dir_cnt = 0;
        read_data_i = op; read_valid_i = 1'b1;
        @(posedge clock); #1;
        read_valid_i = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clock); #1; end
        read_data_i = arg; read_valid_i = 1'b1;
        @(posedge clock); #1;
        read_valid_i = 1'b0;
        if (rst_dly > 0) begin
            repeat (rst_dly - 1) begin @(posedge clock); #1; end
            reset = 1'b0;
            @(posedge clock); #1;
            reset = 1'b1;
            @(negedge clock);
            chk("rst_wr_n", 32'(wr_n_o), 3);
            chk("rst_dir", 32'(dir_o), 0);
            chk("rst_valid", 32'(write_valid_o), 0);
            chk("rst_busy", 32'(busy_o), 0);
            model_reset();
            exp_q.delete();
            return;
        end
        if (inj_dly > 0) begin
            repeat (inj_dly) begin @(posedge clock); #1; end
            read_data_i = 8'h01; read_valid_i = 1'b1;
            m_ovr = 1;
            @(posedge clock); #1;
            read_valid_i = 1'b0;
        end else if (is_read) begin
            lat = 0;
            while (lat < 2000) begin
                @(negedge clock);
                if (write_valid_o) break;
                lat++;
            end
            chk("read_latency", lat, 3 + p);
        end
        t = 0;
        while ((busy_o || write_valid_o) && t < 20000) begin
            @(negedge clock);
            t++;
        end
        chk("idle_timeout", 32'(t < 20000), 1);
        post_check();
    endtask

    task automatic chk_got(input string name, input int idx, input logic [7:0] exp);
        chk(name, (got_q.size() > idx) ? 32'(got_q[idx]) : 32'hDEAD, 32'(exp));
    endtask

    logic [7:0] bad_ops [6];

    initial begin
        bad_ops = '{8'h22, 8'h32, 8'h99, 8'h42, 8'hB1, 8'h7F};
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_addr", 32'(addr_o), 0);
        chk("rst_rd_n", 32'(rd_n_o), 1);
        chk("rst_wr_n0", 32'(wr_n_o), 3);
        chk("rst_dir0", 32'(dir_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_wvalid", 32'(write_valid_o), 0);
        chk("rst_busy0", 32'(busy_o), 0);
        chk("rst_errs", {error_bad_opcode_o, error_overrun_o}, 0);

        got_q.delete();
        send_cmd(8'h01, 8'h5A, 0, 0);
        chk("echo_count", got_q.size(), 1);
        chk_got("echo_byte", 0, 8'h5A);
        chk("echo_busy", 32'(busy_o), 0);

        send_cmd(8'h20, 8'h34, 0, 0);
        send_cmd(8'h21, 8'hF2, 0, 0);
        got_q.delete();
        send_cmd(8'hB0, 8'h00, 0, 0);
        chk_got("getaddr_b0", 0, 8'h72);
        chk_got("getaddr_b1", 1, 8'h34);
        chk("addr_7234", 32'(addr_o), 32'h7234);

        send_cmd(8'h40, 8'h03, 0, 0);
        send_cmd(8'h30, 8'hAA, 0, 0);
        send_cmd(8'h31, 8'h55, 0, 0);
        send_cmd(8'h60, 8'h02, 0, 0);
        chk("write_dir_5", dir_cnt, 5);
        chk("write_wr1_3", wr_low1, 3);
        chk("write_wr0_0", wr_low0, 0);
        chk("data_55aa", 32'(data_o), 32'h55AA);

        rdy_rand = 1'b1;
        send_cmd(8'h41, 8'h01, 0, 0);
        send_cmd(8'h20, 8'hFF, 0, 0);
        send_cmd(8'h21, 8'h7F, 0, 0);
        got_q.delete();
        send_cmd(8'h50, 8'h02, 0, 0);
        chk_got("burst_b0", 0, 8'h22);
        chk_got("burst_b1", 1, 8'h11);
        chk_got("burst_b2", 2, 8'h44);
        chk_got("burst_b3", 3, 8'h33);
        chk("burst_addr_end", 32'(addr_o), 1);

        send_cmd(8'h40, 8'h0A, 0, 0);
        send_cmd(8'h50, 8'h01, 3, 0);
        chk("overrun_set", 32'(error_overrun_o), 1);
        send_cmd(8'h99, 8'h00, 0, 0);
        chk("bad_set", 32'(error_bad_opcode_o), 1);
        send_cmd(8'h10, 8'h00, 0, 0);
        chk("errs_cleared", {error_bad_opcode_o, error_overrun_o}, 0);

        send_cmd(8'h40, 8'd20, 0, 0);
        send_cmd(8'h60, 8'h03, 0, 5);
        got_q.delete();
        send_cmd(8'h01, 8'hC3, 0, 0);
        chk_got("echo_after_rst", 0, 8'hC3);

        for (int k = 0; k < 60; k++) begin
            int sel;
            logic [7:0] a;
            sel = $urandom_range(0, 11);
            a = 8'($urandom);
            case (sel)
                0: send_cmd(8'h01, a, 0, 0);
                1: send_cmd(8'h20 + 8'($urandom_range(0, 1)), a, 0, 0);
                2: send_cmd(8'h30 + 8'($urandom_range(0, 1)), a, 0, 0);
                3: send_cmd(8'h40, 8'($urandom_range(0, 4)), 0, 0);
                4: send_cmd(8'h41, a, 0, 0);
                5, 6: send_cmd(8'h50, 8'($urandom_range(1, 3)), 0, 0);
                7: send_cmd(8'h60, 8'($urandom_range(0, 3)), 0, 0);
                8: send_cmd(8'hB0, a, 0, 0);
                9: send_cmd(bad_ops[$urandom_range(0, 5)], a, 0, 0);
                10: send_cmd(8'h10, a, 0, 0);
                default: send_cmd(8'h00, a, 0, 0);
            endcase
        end

        send_cmd(8'h40, 8'h00, 0, 0);
        send_cmd(8'h50, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
